// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, reset vector and the
// per-edge update selection used by the pipeline stage registers.
package cpu_pkg;

    localparam int          EXC_W    = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // Exception codes carried down the pipeline; zero means "no exception".
    typedef enum logic [EXC_W-1:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // What a stage register does on a given clock edge.
    typedef enum logic [2:0] {
        UPD_REQ,
        UPD_ERET,
        UPD_FLUSH,
        UPD_STALL,
        UPD_LOAD
    } upd_sel_e;

    // Resolve the control inputs into one action: req > eret > flush > stall > load.
    function automatic upd_sel_e pick_update(input logic req, input logic eret,
                                             input logic flush, input logic stall);
        if (req)        return UPD_REQ;
        else if (eret)  return UPD_ERET;
        else if (flush) return UPD_FLUSH;
        else if (stall) return UPD_STALL;
        else            return UPD_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of control, upstream and downstream signals of one pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int TNEW_W = 3,
    parameter int EXC_W  = cpu_pkg::EXC_W
) ();

    logic              req;
    logic              eret;
    logic              flush;
    logic              stall;
    logic [31:0]       EBase;
    logic [31:0]       EPC;

    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;
    logic [TNEW_W-1:0] in_tnew;
    logic [EXC_W-1:0]  in_exc;
    logic              in_valid;
    logic              in_bd;

    logic [31:0]       out_pc;
    logic [31:0]       out_pc_add_8;
    logic [DATA_W-1:0] out_data;
    logic [TNEW_W-1:0] out_tnew;
    logic [EXC_W-1:0]  out_exc;
    logic              out_valid;
    logic              out_bd;
    logic [15:0]       stall_cnt;

    // Driving side: the pipeline controller and the upstream stage.
    modport master (
        output req, eret, flush, stall, EBase, EPC,
        output in_pc, in_data, in_tnew, in_exc, in_valid, in_bd,
        input  out_pc, out_pc_add_8, out_data, out_tnew, out_exc, out_valid, out_bd,
        input  stall_cnt
    );

    // The stage register itself.
    modport slave (
        input  req, eret, flush, stall, EBase, EPC,
        input  in_pc, in_data, in_tnew, in_exc, in_valid, in_bd,
        output out_pc, out_pc_add_8, out_data, out_tnew, out_exc, out_valid, out_bd,
        output stall_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc until saturated; clear has priority.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with exception redirect, ERET redirect, bubble
// insertion and stall hold; Tnew ages while the stage is held.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int          DATA_W   = 128,
    parameter int          TNEW_W   = 3,
    parameter int          EXC_W    = cpu_pkg::EXC_W,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic           clk,
    input  logic           reset,
    pipe_stage_reg_if.slave bus
);

    upd_sel_e          sel;
    logic [31:0]       pc_q,    pc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [TNEW_W-1:0] tnew_q,  tnew_d;
    logic [EXC_W-1:0]  exc_q,   exc_d;
    logic              valid_q, valid_d;
    logic              bd_q,    bd_d;
    logic [TNEW_W-1:0] tnew_dec;
    logic              stall_sel;

    // Tnew aged by one cycle, floored at zero; shared by hold path and output.
    assign tnew_dec  = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);
    assign sel       = pick_update(bus.req, bus.eret, bus.flush, bus.stall);
    assign stall_sel = (sel == UPD_STALL);

    // Next-state selection for the stage contents.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value unassigned (no latch).
        pc_d    = pc_q;
        data_d  = data_q;
        tnew_d  = tnew_q;
        exc_d   = exc_q;
        valid_d = valid_q;
        bd_d    = bd_q;
        unique case (sel)
            UPD_REQ, UPD_ERET: begin
                pc_d    = (sel == UPD_REQ) ? bus.EBase : bus.EPC;
                data_d  = '0;
                tnew_d  = '0;
                exc_d   = '0;
                valid_d = 1'b0;
                bd_d    = 1'b0;
            end
            UPD_FLUSH: begin
                // Keep the PC so the bubble still reports a meaningful macro-PC.
                pc_d    = bus.in_pc;
                bd_d    = bus.in_bd;
                data_d  = '0;
                tnew_d  = '0;
                exc_d   = '0;
                valid_d = 1'b0;
            end
            UPD_STALL: begin
                tnew_d  = tnew_dec;
            end
            UPD_LOAD: begin
                pc_d    = bus.in_pc;
                data_d  = bus.in_data;
                tnew_d  = bus.in_tnew;
                exc_d   = bus.in_exc;
                valid_d = bus.in_valid;
                bd_d    = bus.in_bd;
            end
            default: ;
        endcase
    end

    // Stage contents register; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            data_q  <= '0;
            tnew_q  <= '0;
            exc_q   <= '0;
            valid_q <= 1'b0;
            bd_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            data_q  <= data_d;
            tnew_q  <= tnew_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
            bd_q    <= bd_d;
        end
    end

    // Consecutive-stall counter: any non-stall update ends the hold.
    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!stall_sel),
        .inc   (stall_sel),
        .count (bus.stall_cnt)
    );

    assign bus.out_pc       = pc_q;
    assign bus.out_pc_add_8 = pc_q + 32'd8;
    assign bus.out_data     = data_q;
    assign bus.out_tnew     = tnew_dec;
    assign bus.out_exc      = valid_q ? exc_q : '0;
    assign bus.out_valid    = valid_q;
    assign bus.out_bd       = bd_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128: width of the opaque payload bus (operands, results, control word).
REQ-002 Parameter TNEW_W, default 3: width of the Tnew field.
REQ-003 Parameter EXC_W, default 5: width of the exception code; 0 means no exception.
REQ-004 Parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset (asserted at 0).
REQ-007 Port req, input, 1: exception/interrupt taken; redirect the stage to EBase.
REQ-008 Port eret, input, 1: ERET committing; redirect the stage to EPC.
REQ-009 Port flush, input, 1: insert a bubble while retaining the incoming PC.
REQ-010 Port stall, input, 1: hold the stage contents.
REQ-011 Port EBase, input, 32: exception handler entry address.
REQ-012 Port EPC, input, 32: exception return address.
REQ-013 Ports in_pc (32), in_data (DATA_W), in_tnew (TNEW_W), in_exc (EXC_W), in_valid (1), in_bd (1), all inputs: upstream stage contents.
REQ-014 Ports out_pc (32), out_pc_add_8 (32), out_data (DATA_W), out_tnew (TNEW_W), out_exc (EXC_W), out_valid (1), out_bd (1), all outputs: stage contents.
REQ-015 Port stall_cnt, output, 16: count of consecutive stall cycles in the current hold.

Function
REQ-016 Per-edge update priority SHALL be: req > eret > flush > stall > load.
REQ-017 req SHALL load pc=EBase, data=0, tnew=0, exc=0, valid=0, bd=0.
REQ-018 eret (with req low) SHALL load pc=EPC and clear all other fields, as in REQ-017.
REQ-019 flush SHALL load pc=in_pc and bd=in_bd, and clear data, tnew, exc and valid; the PC is retained so it stays visible as the macro-PC.
REQ-020 stall SHALL hold pc, data, exc, valid and bd, and SHALL decrement the stored tnew by 1 per cycle, saturating at 0.
REQ-021 Load SHALL capture all in_* fields unchanged.
REQ-022 out_tnew SHALL equal the stored tnew minus 1, saturating at 0, computed combinationally.
REQ-023 out_pc_add_8 SHALL equal the stored pc + 8, modulo 2^32 (0xFFFF_FFFC+8 wraps to 0x4).
REQ-024 out_valid=0 SHALL force out_exc=0 combinationally.
REQ-025 stall_cnt SHALL increment on each stall-selected cycle, saturating at 16'hFFFF, and SHALL clear on any non-stall update.
REQ-026 req, eret or flush asserted together with stall SHALL override the stall.

Reset
REQ-027 reset low SHALL immediately set pc=RESET_PC, out_pc_add_8=RESET_PC+8, and data, tnew, exc, valid, bd and stall_cnt to 0, independent of clk.
REQ-028 Deasserting reset mid-stall SHALL leave stall_cnt at 0; the first stall edge after reset brings it to 1.

Structure
REQ-029 EXC_W, the exception code constants (none=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12) and RESET_PC SHALL reside in the shared cpu_pkg package.
REQ-030 The saturating stall counter SHALL be a sub-module named sat_counter, parametrised by width.

Verification
REQ-031 Load in_pc=0x3010, in_tnew=2, in_exc=0, in_valid=1 -> next cycle out_pc=0x3010, out_pc_add_8=0x3018, out_tnew=1.
REQ-032 Stall 3 cycles after loading tnew=3 -> out_tnew goes 1,0,0; stall_cnt goes 1,2,3; pc and data hold.
REQ-033 Assert req, eret and stall together with EBase=0x4180 -> out_pc=0x4180, out_valid=0, stall_cnt=0.
REQ-034 Assert eret with EPC=0x3024 -> out_pc=0x3024, out_pc_add_8=0x302C, out_data=0.
REQ-035 Assert flush with in_pc=0x3040, in_exc=12 -> out_pc=0x3040, out_exc=0, out_valid=0.
REQ-036 Pulse reset low between clock edges while valid=1 -> out_pc=0x3000 and out_valid=0 before the next edge.
